// File: rtl/sap_1_controller_sequencer_pkg.sv
// Shared SAP-1 control-unit definitions: opcode defaults, one-hot T-states, control-word layout.
// Pure declarations; no timing or flow control.
package sap_1_controller_sequencer_pkg;

    localparam logic [3:0] OPC_LDA = 4'h0;
    localparam logic [3:0] OPC_ADD = 4'h1;
    localparam logic [3:0] OPC_SUB = 4'h2;
    localparam logic [3:0] OPC_OUT = 4'hE;
    localparam logic [3:0] OPC_HLT = 4'hF;

    typedef logic [5:0] tstate_t;

    localparam tstate_t T1 = 6'b000001;
    localparam tstate_t T2 = 6'b000010;
    localparam tstate_t T3 = 6'b000100;
    localparam tstate_t T4 = 6'b001000;
    localparam tstate_t T5 = 6'b010000;
    localparam tstate_t T6 = 6'b100000;

    // Control word packed as {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    typedef logic [11:0] cw_t;

    typedef enum logic [2:0] {
        OPK_LDA,
        OPK_ADD,
        OPK_SUB,
        OPK_OUT,
        OPK_HLT,
        OPK_ILL
    } opk_t;

endpackage

// File: rtl/sap_1_controller_sequencer_if.sv
// Sequencer-to-datapath bundle: run/step/opcode in, T-state, control word and status out.
// master = environment side driving run/step/opcode; slave = the sequencer.
interface sap_1_controller_sequencer_if #(
    parameter int OPCODE_WIDTH = 4
);
    logic                    run;
    logic                    step;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [5:0]              t_state;
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
    logic                    halted;
    logic                    illegal_op;

    modport master (
        output run, step, opcode,
        input  t_state, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, halted, illegal_op
    );

    modport slave (
        input  run, step, opcode,
        output t_state, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, halted, illegal_op
    );
endinterface

// File: rtl/sap_1_controller_sequencer_ring_counter.sv
// One-hot T1..T6 rotator; advances when en, jumps to T1 instead when wrap is also set.
// State changes on the clock edge after en; holds otherwise; clr returns to T1 asynchronously.
module sap_1_ring_counter
    import sap_1_controller_sequencer_pkg::*;
(
    input  logic    clk,
    input  logic    clr,
    input  logic    en,
    input  logic    wrap,
    output tstate_t t_state
);
    tstate_t t_q;
    tstate_t t_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            t_q <= T1;
        end else begin
            t_q <= t_d;
        end
    end

    always_comb begin
        t_d = t_q;
        if (en) begin
            t_d = wrap ? T1 : {t_q[4:0], t_q[5]};
        end
    end

    assign t_state = t_q;

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 control unit: T-state sequencing, opcode decode, halt latch and illegal-opcode flag.
// Control word is combinational from T-state/opcode; run=0 gates it to the step cycle only.
module sap_1_controller_sequencer
    import sap_1_controller_sequencer_pkg::*;
#(
    parameter int                      OPCODE_WIDTH   = 4,
    parameter logic [OPCODE_WIDTH-1:0] OP_LDA         = OPCODE_WIDTH'(OPC_LDA),
    parameter logic [OPCODE_WIDTH-1:0] OP_ADD         = OPCODE_WIDTH'(OPC_ADD),
    parameter logic [OPCODE_WIDTH-1:0] OP_SUB         = OPCODE_WIDTH'(OPC_SUB),
    parameter logic [OPCODE_WIDTH-1:0] OP_OUT         = OPCODE_WIDTH'(OPC_OUT),
    parameter logic [OPCODE_WIDTH-1:0] OP_HLT         = OPCODE_WIDTH'(OPC_HLT),
    parameter bit                      VARIABLE_CYCLE = 1'b0
) (
    input logic                          clk,
    input logic                          clr,
    sap_1_controller_sequencer_if.slave  bus
);
    tstate_t t_state;
    opk_t    opk;
    cw_t     cw_raw;
    cw_t     cw;
    logic    adv;
    logic    hlt_now;
    logic    ring_en;
    logic    early_wrap;
    logic    halted_q;
    logic    halted_d;

    always_comb begin
        opk = OPK_ILL;
        if      (bus.opcode == OP_LDA) opk = OPK_LDA;
        else if (bus.opcode == OP_ADD) opk = OPK_ADD;
        else if (bus.opcode == OP_SUB) opk = OPK_SUB;
        else if (bus.opcode == OP_OUT) opk = OPK_OUT;
        else if (bus.opcode == OP_HLT) opk = OPK_HLT;
    end

    assign adv     = !halted_q && (bus.run || bus.step);
    // HLT freezes the ring at T4: the halting advance latches halted instead of rotating
    assign hlt_now = adv && t_state[3] && (opk == OPK_HLT);
    assign ring_en = adv && !hlt_now;
    assign early_wrap = VARIABLE_CYCLE &&
                        ((t_state[3] && (opk == OPK_OUT)) || (t_state[4] && (opk == OPK_LDA)));

    sap_1_ring_counter u_ring (
        .clk     (clk),
        .clr     (clr),
        .en      (ring_en),
        .wrap    (early_wrap),
        .t_state (t_state)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    always_comb begin
        halted_d = halted_q | hlt_now;
    end

    always_comb begin
        cw_raw = '0;
        case (t_state)
            T1: begin
                cw_raw[CW_EP] = 1'b1;
                cw_raw[CW_LM] = 1'b1;
            end
            T2: cw_raw[CW_CP] = 1'b1;
            T3: begin
                cw_raw[CW_CE] = 1'b1;
                cw_raw[CW_LI] = 1'b1;
            end
            T4: begin
                if (opk == OPK_LDA || opk == OPK_ADD || opk == OPK_SUB) begin
                    cw_raw[CW_EI] = 1'b1;
                    cw_raw[CW_LM] = 1'b1;
                end else if (opk == OPK_OUT) begin
                    cw_raw[CW_EA] = 1'b1;
                    cw_raw[CW_LO] = 1'b1;
                end
            end
            T5: begin
                if (opk == OPK_LDA) begin
                    cw_raw[CW_CE] = 1'b1;
                    cw_raw[CW_LA] = 1'b1;
                end else if (opk == OPK_ADD || opk == OPK_SUB) begin
                    cw_raw[CW_CE] = 1'b1;
                    cw_raw[CW_LB] = 1'b1;
                end
            end
            T6: begin
                if (opk == OPK_ADD || opk == OPK_SUB) begin
                    cw_raw[CW_LA] = 1'b1;
                    cw_raw[CW_EU] = 1'b1;
                    cw_raw[CW_SU] = (opk == OPK_SUB);
                end
            end
            default: cw_raw = '0;
        endcase
    end

    // Enables only in cycles that actually advance, so step-mode loads fire once per pulse
    assign cw = (adv && !clr) ? cw_raw : '0;

    assign bus.t_state    = t_state;
    assign bus.halted     = halted_q;
    assign bus.illegal_op = adv && !clr && t_state[3] && (opk == OPK_ILL);

    assign bus.cp = cw[CW_CP];
    assign bus.ep = cw[CW_EP];
    assign bus.lm = cw[CW_LM];
    assign bus.ce = cw[CW_CE];
    assign bus.li = cw[CW_LI];
    assign bus.ei = cw[CW_EI];
    assign bus.la = cw[CW_LA];
    assign bus.ea = cw[CW_EA];
    assign bus.su = cw[CW_SU];
    assign bus.eu = cw[CW_EU];
    assign bus.lb = cw[CW_LB];
    assign bus.lo = cw[CW_LO];

endmodule
